// File: rtl/seg7_scan_driver_if.sv
// Bundle between the BCD digit source and the multiplexed seven-segment driver.
// The master supplies digits and display controls; the slave drives the segment and anode lines.
interface seg7_scan_driver_if;
   logic [15:0] digits;
   logic [3:0]  dp_in;
   logic        load;
   logic [3:0]  en_mask;
   logic        lzb;
   logic [7:0]  out;
   logic [3:0]  am;
   logic        frame_tick;

   modport master (
      output digits, dp_in, load, en_mask, lzb,
      input  out, am, frame_tick
   );

   modport slave (
      input  digits, dp_in, load, en_mask, lzb,
      output out, am, frame_tick
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver with frame-aligned double buffering,
// anti-ghosting blanking at each digit switch, per-digit enables and leading-zero blanking.
module seg7_scan_driver #(
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input logic               clk,
   input logic               reset,
   seg7_scan_driver_if.slave bus
);

   localparam int            CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

   logic [CW-1:0] cnt;
   logic [1:0]    slot;
   logic          cnt_wrap;
   logic          frame_wrap;

   logic [15:0]   pend_digits;
   logic [3:0]    pend_dp;
   logic          pend_flag;
   logic [15:0]   disp_digits;
   logic [3:0]    disp_dp;

   logic [3:0]    cur_digit;
   logic [3:0]    lz_blank;
   logic [3:0]    next_am;
   logic [7:0]    next_out;

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'b0000001;
         4'd1:    s = 7'b1001111;
         4'd2:    s = 7'b0010010;
         4'd3:    s = 7'b0000110;
         4'd4:    s = 7'b1001100;
         4'd5:    s = 7'b0100100;
         4'd6:    s = 7'b1100000;
         4'd7:    s = 7'b0001101;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0000100;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   assign cnt_wrap   = (cnt == CNT_MAX);
   assign frame_wrap = cnt_wrap && (slot == 2'd3);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt  <= '0;
         slot <= '0;
      end else if (cnt_wrap) begin
         cnt  <= '0;
         slot <= slot + 2'd1;
      end else begin
         cnt  <= cnt + CW'(1);
      end
   end

   // The display copy reads the old pending value, so a load on the wrap edge waits one frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_digits <= '0;
         pend_dp     <= '0;
         pend_flag   <= 1'b0;
         disp_digits <= '0;
         disp_dp     <= '0;
      end else begin
         if (frame_wrap && pend_flag) begin
            disp_digits <= pend_digits;
            disp_dp     <= pend_dp;
            pend_flag   <= 1'b0;
         end
         if (bus.load) begin
            pend_digits <= bus.digits;
            pend_dp     <= bus.dp_in;
            pend_flag   <= 1'b1;
         end
      end
   end

   always_comb begin
      cur_digit = disp_digits[{slot, 2'b00} +: 4];
      lz_blank  = '0;
      if (bus.lzb) begin
         lz_blank[3] = (disp_digits[15:12] == 4'd0);
         lz_blank[2] = lz_blank[3] && (disp_digits[11:8] == 4'd0);
         lz_blank[1] = lz_blank[2] && (disp_digits[7:4] == 4'd0);
      end
      next_am  = 4'b1111;
      next_out = 8'hFF;
      if ((cnt >= BLANK_END) && bus.en_mask[slot]) begin
         next_am[slot] = 1'b0;
         next_out      = {lz_blank[slot] ? 7'b1111111 : seg_decode(cur_digit), ~disp_dp[slot]};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.am         <= 4'b1111;
         bus.out        <= 8'hFF;
         bus.frame_tick <= 1'b0;
      end else begin
         bus.am         <= next_am;
         bus.out        <= next_out;
         bus.frame_tick <= frame_wrap;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized and directed bench for seg7_scan_driver, checked every cycle against a
// frame-position reference model derived from the elapsed cycle count.
module tb_seg7_scan_driver;

   localparam int SD = 8;
   localparam int BC = 2;
   localparam int FRAME = 4 * SD;

   logic clk = 1'b0;
   logic reset;

   seg7_scan_driver_if bus();

   seg7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   int          n;
   logic [15:0] m_pend;
   logic [15:0] m_disp;
   logic [3:0]  m_pdp;
   logic [3:0]  m_ddp;
   logic        m_flag;
   logic [6:0]  seg_table [16];
   int          seen_one;
   bit          watch_one;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // One clock: expectation comes from the frame position n and the buffered digits before the edge.
   task automatic applyStimulus();
      logic [3:0] eam;
      logic [7:0] eout;
      logic       eft;
      logic       blank;
      int         pos;
      int         sl;
      int         d;
      pos  = n % SD;
      sl   = (n / SD) % 4;
      eam  = 4'b1111;
      eout = 8'hFF;
      if (pos >= BC && bus.en_mask[sl]) begin
         d       = int'(m_disp[sl*4 +: 4]);
         blank   = bus.lzb && (sl != 0) && ((m_disp >> (sl * 4)) == 16'h0);
         eam[sl] = 1'b0;
         eout    = {blank ? 7'h7F : seg_table[d], ~m_ddp[sl]};
      end
      eft = ((n % FRAME) == FRAME - 1);
      if (eft && m_flag) begin
         m_disp = m_pend;
         m_ddp  = m_pdp;
         m_flag = 1'b0;
      end
      if (bus.load) begin
         m_pend = bus.digits;
         m_pdp  = bus.dp_in;
         m_flag = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
      checkOutput($sformatf("am@%0d", n), 32'(bus.am), 32'(eam));
      checkOutput($sformatf("out@%0d", n), 32'(bus.out), 32'(eout));
      checkOutput($sformatf("tick@%0d", n), 32'(bus.frame_tick), 32'(eft));
      if (watch_one && bus.am != 4'b1111 && bus.out[7:1] == 7'b1001111) seen_one++;
   endtask

   task automatic step(input int k);
      for (int i = 0; i < k; i++) applyStimulus();
   endtask

   task automatic doLoad(input logic [15:0] d, input logic [3:0] dp);
      bus.digits = d;
      bus.dp_in  = dp;
      bus.load   = 1'b1;
      applyStimulus();
      bus.load   = 1'b0;
   endtask

   task automatic waitTick();
      bit found;
      found = 1'b0;
      for (int i = 0; i < FRAME + 8 && !found; i++) begin
         applyStimulus();
         if (bus.frame_tick) found = 1'b1;
      end
      if (!found) checkOutput("tick_timeout", 32'(0), 32'(1));
   endtask

   // Walks one slot from its first edge, checking every visible cycle against fixed values.
   task automatic checkSlot(input string tag, input logic [3:0] want_am, input logic [7:0] want_out);
      step(BC);
      for (int i = 0; i < SD - BC; i++) begin
         applyStimulus();
         checkOutput({tag, "_am"}, 32'(bus.am), 32'(want_am));
         checkOutput({tag, "_out"}, 32'(bus.out), 32'(want_out));
      end
   endtask

   task automatic stepToWrapEdge();
      for (int i = 0; i < FRAME && (n % FRAME) != FRAME - 1; i++) applyStimulus();
   endtask

   initial begin
      int period;
      int slot2_on;
      bit found;
      seg_table = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b1100000, 7'b0001101,
                    7'b0000000, 7'b0000100, 7'b1111111, 7'b1111111,
                    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
      reset       = 1'b0;
      bus.digits  = '0;
      bus.dp_in   = '0;
      bus.load    = 1'b0;
      bus.en_mask = 4'b1111;
      bus.lzb     = 1'b0;
      watch_one   = 1'b0;
      seen_one    = 0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_am", 32'(bus.am), 32'(4'b1111));
      checkOutput("rst_out", 32'(bus.out), 32'(8'hFF));
      checkOutput("rst_tick", 32'(bus.frame_tick), 32'(0));
      #4;
      reset  = 1'b1;
      n      = 0;
      m_pend = '0;
      m_disp = '0;
      m_pdp  = '0;
      m_ddp  = '0;
      m_flag = 1'b0;

      $display("[TB] normal display 1234");
      doLoad(16'h1234, 4'b0000);
      waitTick();
      checkSlot("n_s0", 4'b1110, 8'h99);
      step(2 * SD);
      checkSlot("n_s3", 4'b0111, 8'h9F);

      $display("[TB] leading-zero blanking 0050");
      doLoad(16'h0050, 4'b0000);
      bus.lzb = 1'b1;
      waitTick();
      checkSlot("lz_s0", 4'b1110, 8'h03);
      checkSlot("lz_s1", 4'b1101, 8'h49);
      checkSlot("lz_s2", 4'b1011, 8'hFF);
      checkSlot("lz_s3", 4'b0111, 8'hFF);
      bus.lzb = 1'b0;
      checkSlot("nlz_s0", 4'b1110, 8'h03);
      checkSlot("nlz_s1", 4'b1101, 8'h49);
      checkSlot("nlz_s2", 4'b1011, 8'h03);
      checkSlot("nlz_s3", 4'b0111, 8'h03);

      $display("[TB] double buffering");
      watch_one = 1'b1;
      step(10);
      doLoad(16'h1111, 4'b0000);
      step(5);
      doLoad(16'h2222, 4'b0000);
      waitTick();
      checkSlot("tear_s0", 4'b1110, 8'h25);
      step(3 * SD);
      watch_one = 1'b0;
      checkOutput("no_tear", 32'(seen_one), 32'(0));
      stepToWrapEdge();
      doLoad(16'h3333, 4'b0000);
      checkSlot("wrapld_old", 4'b1110, 8'h25);
      step(3 * SD);
      checkSlot("wrapld_new", 4'b1110, 8'h0D);
      step(3 * SD);
      step(5);
      doLoad(16'h4444, 4'b0000);
      stepToWrapEdge();
      doLoad(16'h5555, 4'b0000);
      checkSlot("wrap2_prev", 4'b1110, 8'h99);
      step(3 * SD);
      checkSlot("wrap2_new", 4'b1110, 8'h49);
      step(3 * SD);

      $display("[TB] edge cases");
      doLoad(16'h000A, 4'b0000);
      waitTick();
      checkSlot("hexA", 4'b1110, 8'hFF);
      doLoad(16'h0008, 4'b0001);
      waitTick();
      checkSlot("eight_dp", 4'b1110, 8'h00);
      step(3 * SD);
      bus.en_mask = 4'b1011;
      period   = 0;
      slot2_on = 0;
      found    = 1'b0;
      for (int i = 0; i < FRAME + 8 && !found; i++) begin
         applyStimulus();
         period++;
         if (bus.am[2] == 1'b0) slot2_on++;
         if (bus.frame_tick) found = 1'b1;
      end
      checkOutput("mask_period", 32'(period), 32'(FRAME));
      checkOutput("mask_slot2", 32'(slot2_on), 32'(0));
      bus.en_mask = 4'b1111;

      $display("[TB] randomized traffic");
      for (int i = 0; i < 900; i++) begin
         logic [15:0] rd;
         for (int k = 0; k < 4; k++)
            rd[k*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         bus.digits = rd;
         bus.dp_in  = 4'($urandom);
         bus.load   = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 49) == 0) bus.en_mask = 4'($urandom);
         if ($urandom_range(0, 49) == 0) bus.lzb = 1'($urandom);
         applyStimulus();
      end
      bus.load    = 1'b0;
      bus.en_mask = 4'b1111;

      $display("[TB] asynchronous reset mid-slot");
      found = 1'b0;
      for (int i = 0; i < FRAME + 8 && !found; i++) begin
         applyStimulus();
         if (bus.am == 4'b1110) found = 1'b1;
      end
      checkOutput("am_1110_seen", 32'(found), 32'(1));
      #2;
      reset = 1'b0;
      #1;
      checkOutput("arst_am", 32'(bus.am), 32'(4'b1111));
      checkOutput("arst_out", 32'(bus.out), 32'(8'hFF));
      checkOutput("arst_tick", 32'(bus.frame_tick), 32'(0));
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checkOutput("arst_hold_am", 32'(bus.am), 32'(4'b1111));
         checkOutput("arst_hold_out", 32'(bus.out), 32'(8'hFF));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
